// File: rtl/btb_update_ctrl_if.sv
// rtl/btb_update_ctrl_if.sv - resolved-branch inputs and BTB update/invalidate outputs
interface btb_update_ctrl_if #(
  parameter int INDEX_WIDTH = 5
);
  logic                   br0_valid;
  logic                   br0_taken;
  logic [31:0]            br0_addr;
  logic [31:0]            br0_target;
  logic                   br1_valid;
  logic                   br1_taken;
  logic [31:0]            br1_addr;
  logic [31:0]            br1_target;
  logic                   flush_req;
  logic                   upd_valid;
  logic [31:0]            upd_addr;
  logic [31:0]            upd_target;
  logic                   inval_we;
  logic [INDEX_WIDTH-1:0] inval_index;
  logic                   flush_busy;
  logic                   flush_done;
  logic [7:0]             drop_cnt;

  modport master (
    output br0_valid, br0_taken, br0_addr, br0_target,
    output br1_valid, br1_taken, br1_addr, br1_target,
    output flush_req,
    input  upd_valid, upd_addr, upd_target,
    input  inval_we, inval_index, flush_busy, flush_done, drop_cnt
  );

  modport slave (
    input  br0_valid, br0_taken, br0_addr, br0_target,
    input  br1_valid, br1_taken, br1_addr, br1_target,
    input  flush_req,
    output upd_valid, upd_addr, upd_target,
    output inval_we, inval_index, flush_busy, flush_done, drop_cnt
  );
endinterface

// File: rtl/btb_update_ctrl.sv
// rtl/btb_update_ctrl.sv - queues taken-branch BTB updates and sweeps the BTB on flush
module btb_update_ctrl #(
  parameter int ENTRY_NUM   = 32,
  parameter int INDEX_WIDTH = $clog2(ENTRY_NUM),
  parameter int FIFO_DEPTH  = 4
) (
  input logic              clk,
  input logic              rst,
  btb_update_ctrl_if.slave bus
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int FREE_W = CNT_W + 1;
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(ENTRY_NUM - 1);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_DONE} state_t;
  state_t state, state_nxt;

  logic [31:0]            fifo_addr [FIFO_DEPTH];
  logic [31:0]            fifo_tgt  [FIFO_DEPTH];
  logic [PTR_W-1:0]       rd_ptr, wr_ptr, wr_ptr_p1, wr_idx1;
  logic [CNT_W-1:0]       count;
  logic [INDEX_WIDTH-1:0] sweep_idx;
  logic [7:0]             drop_cnt;

  logic              fifo_empty, pop, flush_start, accept_br;
  logic              cand0, cand1, push0, push1;
  logic [FREE_W-1:0] free_slots;
  logic [1:0]        n_cand, n_push, n_drop;
  logic [8:0]        drop_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    flush_start     = 1'b0;
    bus.upd_valid   = 1'b0;
    bus.upd_addr    = '0;
    bus.upd_target  = '0;
    bus.inval_we    = 1'b0;
    bus.inval_index = '0;
    bus.flush_busy  = 1'b0;
    bus.flush_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          bus.upd_valid  = 1'b1;
          bus.upd_addr   = fifo_addr[rd_ptr];
          bus.upd_target = fifo_tgt[rd_ptr];
        end
        if (bus.flush_req) begin
          state_nxt   = S_FLUSH;
          flush_start = 1'b1;
        end
      end
      S_FLUSH: begin
        bus.inval_we    = 1'b1;
        bus.inval_index = sweep_idx;
        bus.flush_busy  = 1'b1;
        if (sweep_idx == LAST_IDX) state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.flush_done = 1'b1;
        state_nxt      = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.drop_cnt = drop_cnt;
  assign fifo_empty   = (count == '0);
  assign pop          = (state == S_IDLE) && !fifo_empty;
  assign wr_ptr_p1    = wr_ptr + PTR_W'(1);

  // Branches are only accepted in IDLE and never alongside a flush; those
  // discards are silent, unlike capacity drops.
  always_comb begin
    accept_br  = (state == S_IDLE) && !bus.flush_req;
    cand1      = bus.br1_valid && bus.br1_taken;
    cand0      = bus.br0_valid && bus.br0_taken && !(cand1 && (bus.br0_addr == bus.br1_addr));
    free_slots = FREE_W'(FIFO_DEPTH) - {1'b0, count} + FREE_W'(pop);
    push0      = accept_br && cand0 && (free_slots != '0);
    push1      = accept_br && cand1 &&
                 (cand0 ? (free_slots >= FREE_W'(2)) : (free_slots != '0));
    wr_idx1    = push0 ? wr_ptr_p1 : wr_ptr;
    n_cand     = accept_br ? ({1'b0, cand0} + {1'b0, cand1}) : 2'd0;
    n_push     = {1'b0, push0} + {1'b0, push1};
    n_drop     = n_cand - n_push;
    drop_sum   = {1'b0, drop_cnt} + {7'b0, n_drop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      sweep_idx <= '0;
      drop_cnt  <= '0;
    end else begin
      if (flush_start) begin
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        count     <= '0;
        sweep_idx <= '0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        wr_ptr   <= wr_ptr + PTR_W'(n_push);
        count    <= count - CNT_W'(pop) + CNT_W'(n_push);
        drop_cnt <= (drop_sum > 9'd255) ? 8'hff : drop_sum[7:0];
        if (state == S_FLUSH) sweep_idx <= sweep_idx + INDEX_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push0) begin
      fifo_addr[wr_ptr] <= bus.br0_addr;
      fifo_tgt[wr_ptr]  <= bus.br0_target;
    end
    if (push1) begin
      fifo_addr[wr_idx1] <= bus.br1_addr;
      fifo_tgt[wr_idx1]  <= bus.br1_target;
    end
  end
endmodule
